nns_seq_ctrl_td: RTL and testbench



---
 rtl/nns_seq_ctrl_td_pkg.sv | 23 ++
 rtl/nns_seq_ctrl_td_dist.sv | 23 ++
 rtl/nns_seq_ctrl_td.sv | 162 ++++++++++++++++
 tb/tb_nns_seq_ctrl_td.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nns_seq_ctrl_td_pkg.sv
// Shared definitions for the sequential nearest-neighbour scheduler:
// FSM state encodings, distance-width margin and the index-width helper.
package nns_seq_ctrl_td_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Taxicab distance of two W-bit coordinate pairs is carried in W+2 bits.
  localparam int DIST_EXTRA = 2;

  // Ceiling log2, never less than 1 so a one-point search still has an index bit.
  function automatic int log2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/nns_seq_ctrl_td_dist.sv
// Taxicab distance unit: |x1-x2| + |y1-y2| on {x, y} packed points, unsigned.
module nns_seq_ctrl_td_dist #(
  parameter int W = 15
) (
  input  logic [2*W-1:0] a_i,
  input  logic [2*W-1:0] b_i,
  output logic [W+1:0]   dist_o
);

  logic [W-1:0] ax, ay, bx, by;
  logic [W-1:0] dx, dy;

  assign ax = a_i[2*W-1:W];
  assign ay = a_i[W-1:0];
  assign bx = b_i[2*W-1:W];
  assign by = b_i[W-1:0];

  assign dx = (ax >= bx) ? (ax - bx) : (bx - ax);
  assign dy = (ay >= by) ? (ay - by) : (by - ay);

  assign dist_o = {2'b00, dx} + {2'b00, dy};

endmodule

// File: rtl/nns_seq_ctrl_td.sv
// Sequential nearest-neighbour scheduler: one distance unit shared over N streamed points.
// Define NNS_DIST_PIPE_EN to register the distance ahead of the compare (adds a FLUSH cycle).
module nns_seq_ctrl_td
  import nns_seq_ctrl_td_pkg::*;
#(
  parameter  int W    = 15,
  parameter  int N    = 32,
  localparam int LOGN = log2_min1(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*W-1:0]  g_input,
  input  logic            e_valid,
  output logic            e_ready,
  input  logic [2*W-1:0]  e_input,
  output logic [2*W-1:0]  o,
  output logic [LOGN-1:0] o_idx,
  output logic            done,
  output logic            busy
);

  localparam int DW = W + DIST_EXTRA;
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  state_e          state_q, state_d;
  logic [2*W-1:0]  query_q, query_d;
  logic [LOGN-1:0] count_q, count_d;
  logic [DW-1:0]   min_dist_q, min_dist_d;
  logic [2*W-1:0]  best_pt_q, best_pt_d;
  logic [LOGN-1:0] best_idx_q, best_idx_d;
  logic [2*W-1:0]  o_q, o_d;
  logic [LOGN-1:0] o_idx_q, o_idx_d;

  logic [DW-1:0]   dist_w;
  logic            accept;
  logic            cmp_valid, cmp_first;
  logic [DW-1:0]   cmp_dist;
  logic [2*W-1:0]  cmp_pt;
  logic [LOGN-1:0] cmp_idx;

  nns_seq_ctrl_td_dist #(.W(W)) u_dist (
    .a_i    (query_q),
    .b_i    (e_input),
    .dist_o (dist_w)
  );

  assign accept = (state_q == ST_RUN) && e_valid;

`ifdef NNS_DIST_PIPE_EN
  logic            stg_valid_q, stg_first_q;
  logic [DW-1:0]   stg_dist_q;
  logic [2*W-1:0]  stg_pt_q;
  logic [LOGN-1:0] stg_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_first_q <= 1'b0;
      stg_dist_q  <= '0;
      stg_pt_q    <= '0;
      stg_idx_q   <= '0;
    end else begin
      stg_valid_q <= accept;
      stg_first_q <= (count_q == '0);
      stg_dist_q  <= dist_w;
      stg_pt_q    <= e_input;
      stg_idx_q   <= count_q;
    end
  end

  assign cmp_valid = stg_valid_q;
  assign cmp_first = stg_first_q;
  assign cmp_dist  = stg_dist_q;
  assign cmp_pt    = stg_pt_q;
  assign cmp_idx   = stg_idx_q;
`else
  assign cmp_valid = accept;
  assign cmp_first = (count_q == '0);
  assign cmp_dist  = dist_w;
  assign cmp_pt    = e_input;
  assign cmp_idx   = count_q;
`endif

  always_comb begin
    state_d    = state_q;
    query_d    = query_q;
    count_d    = count_q;
    min_dist_d = min_dist_q;
    best_pt_d  = best_pt_q;
    best_idx_d = best_idx_q;
    o_d        = o_q;
    o_idx_d    = o_idx_q;

    // Strict compare: on a tie the earlier point is kept.
    if (cmp_valid && (cmp_first || (min_dist_q > cmp_dist))) begin
      min_dist_d = cmp_dist;
      best_pt_d  = cmp_pt;
      best_idx_d = cmp_idx;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          query_d = g_input;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
`ifdef NNS_DIST_PIPE_EN
            state_d = ST_FLUSH;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Result registers load on DONE entry so they are already valid during the pulse.
    if (state_d == ST_DONE) begin
      o_d     = best_pt_d;
      o_idx_d = best_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      query_q    <= '0;
      count_q    <= '0;
      min_dist_q <= '0;
      best_pt_q  <= '0;
      best_idx_q <= '0;
      o_q        <= '0;
      o_idx_q    <= '0;
    end else begin
      state_q    <= state_d;
      query_q    <= query_d;
      count_q    <= count_d;
      min_dist_q <= min_dist_d;
      best_pt_q  <= best_pt_d;
      best_idx_q <= best_idx_d;
      o_q        <= o_d;
      o_idx_q    <= o_idx_d;
    end
  end

  assign e_ready = (state_q == ST_RUN);
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign o       = o_q;
  assign o_idx   = o_idx_q;

endmodule

// File: tb/tb_nns_seq_ctrl_td.sv
// Bench for nns_seq_ctrl_td at W=4, N=4 plus a single-point (N=1) instance.
module tb_nns_seq_ctrl_td;

`ifdef NNS_DIST_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] g_input = '0;
  logic       e_valid = 1'b0;
  logic       e_ready;
  logic [7:0] e_input = '0;
  logic [7:0] o;
  logic [1:0] o_idx;
  logic       done, busy;

  logic       s1_start = 1'b0;
  logic [7:0] g1 = '0;
  logic       s1_valid = 1'b0;
  logic       ready1;
  logic [7:0] s1_in = '0;
  logic [7:0] o1;
  logic [0:0] o1_idx;
  logic       done1, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nns_seq_ctrl_td #(.W(4), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .g_input(g_input),
    .e_valid(e_valid), .e_ready(e_ready), .e_input(e_input),
    .o(o), .o_idx(o_idx), .done(done), .busy(busy)
  );

  nns_seq_ctrl_td #(.W(4), .N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .g_input(g1),
    .e_valid(s1_valid), .e_ready(ready1), .e_input(s1_in),
    .o(o1), .o_idx(o1_idx), .done(done1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0]      q;
    logic [3:0][7:0] p;
    logic [6:0]      vpat;
    logic            restart;
    logic [7:0]      exp_o;
    logic [1:0]      exp_idx;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int absdiff(input logic [3:0] a, input logic [3:0] b);
    int d;
    d = int'({28'd0, a}) - int'({28'd0, b});
    return (d < 0) ? -d : d;
  endfunction

  // Reference: first point with the smallest taxicab distance wins.
  function automatic logic [9:0] model(input logic [7:0] q, input logic [3:0][7:0] p);
    int best, bi, d;
    best = 0;
    bi = 0;
    for (int i = 0; i < 4; i++) begin
      d = absdiff(q[7:4], p[i][7:4]) + absdiff(q[3:0], p[i][3:0]);
      if (i == 0 || d < best) begin
        best = d;
        bi = i;
      end
    end
    return {bi[1:0], p[bi]};
  endfunction

  task automatic run_search(input logic [7:0] q, input logic [3:0][7:0] p,
                            input logic [6:0] vpat, input bit rnd, input bit restart,
                            input logic [7:0] exp_o, input logic [1:0] exp_idx);
    int k, cyc, lat;
    bit early;
    logic [7:0] got_o;
    logic [1:0] got_idx;
    @(posedge clk); #1;
    start = 1'b1; g_input = q; e_valid = 1'b0; e_input = 8'($urandom);
    @(negedge clk);
    k = 0; cyc = 0; early = 0;
    while (k < 4 && cyc < 200) begin
      @(posedge clk); #1;
      start   = restart && (cyc == 1);
      g_input = start ? ~q : 8'($urandom);
      e_valid = rnd ? ($urandom_range(0, 2) != 0) : ((cyc < 7) ? vpat[cyc] : 1'b1);
      e_input = e_valid ? p[k] : 8'($urandom);
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_in_run", busy, 1);
        check("ready_in_run", e_ready, 1);
      end
      if (restart && cyc == 1) check("busy_on_restart", busy, 1);
      if (done) early = 1;
      if (e_valid && e_ready) k++;
      cyc++;
    end
    check("all_accepted", k, 4);
    check("no_early_done", early, 0);
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      start = 1'b0; e_valid = 1'($urandom); e_input = 8'($urandom);
      lat++;
      @(negedge clk);
      if (!done) check("ready_low_after_last", e_ready, 0);
    end
    check("done_latency", lat, LAT);
    got_o = o;
    got_idx = o_idx;
    check("result_o", got_o, exp_o);
    check("result_idx", got_idx, exp_idx);
    @(posedge clk); #1;
    e_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_drops", busy, 0);
    check("o_held", o, exp_o);
    $display("search q=%h pts=%h o=%h idx=%0d lat=%0d restart=%0d", q, p, got_o, got_idx, lat, restart);
  endtask

  initial begin
    logic [3:0][7:0] rp;
    logic [7:0]      rq;
    logic [9:0]      m;
    int              lat1;

    tbl[0] = '{q:8'h55, p:{8'h59, 8'h75, 8'h64, 8'h00}, vpat:7'h7F, restart:1'b0, exp_o:8'h64, exp_idx:2'd1};
    tbl[1] = '{q:8'h55, p:{8'h59, 8'h75, 8'h64, 8'h00}, vpat:7'b1011001, restart:1'b0, exp_o:8'h64, exp_idx:2'd1};
    tbl[2] = '{q:8'h55, p:{8'h59, 8'h75, 8'h64, 8'h00}, vpat:7'h7F, restart:1'b1, exp_o:8'h64, exp_idx:2'd1};
    tbl[3] = '{q:8'h00, p:{8'hFF, 8'h0F, 8'hFF, 8'hFF}, vpat:7'h7F, restart:1'b0, exp_o:8'h0F, exp_idx:2'd2};
    tbl[4] = '{q:8'h33, p:{8'h33, 8'h22, 8'h11, 8'h00}, vpat:7'b0110101, restart:1'b0, exp_o:8'h33, exp_idx:2'd3};
    tbl[5] = '{q:8'h88, p:{8'h87, 8'h89, 8'h88, 8'h88}, vpat:7'h7F, restart:1'b1, exp_o:8'h88, exp_idx:2'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o", o, 0);
    check("rst_idx", o_idx, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", e_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_search(tbl[i].q, tbl[i].p, tbl[i].vpat, 1'b0, tbl[i].restart, tbl[i].exp_o, tbl[i].exp_idx);

    // Abort after two accepted entries; previous result 8'h88 must be wiped.
    @(posedge clk); #1;
    start = 1'b1; g_input = 8'h55;
    @(posedge clk); #1;
    start = 1'b0; e_valid = 1'b1; e_input = 8'h00;
    @(posedge clk); #1;
    e_input = 8'h64;
    @(posedge clk); #1;
    e_input = 8'h75;
    rst_n = 1'b0;
    #1;
    check("abort_o", o, 0);
    check("abort_idx", o_idx, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", e_ready, 0);
    check("abort_done", done, 0);
    e_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_search(tbl[0].q, tbl[0].p, tbl[0].vpat, 1'b0, 1'b0, tbl[0].exp_o, tbl[0].exp_idx);

    for (int i = 0; i < 24; i++) begin
      rq = 8'($urandom);
      for (int j = 0; j < 4; j++) rp[j] = 8'($urandom);
      if (i % 3 == 0) rp[3] = rp[1];
      m = model(rq, rp);
      run_search(rq, rp, 7'h00, 1'b1, ($urandom_range(0, 3) == 0), m[7:0], m[9:8]);
    end

    // Single-point search on the N=1 instance.
    @(posedge clk); #1;
    s1_start = 1'b1; g1 = 8'h55;
    @(negedge clk);
    @(posedge clk); #1;
    s1_start = 1'b0; s1_valid = 1'b1; s1_in = 8'h9A;
    @(negedge clk);
    check("n1_ready", ready1, 1);
    lat1 = 0;
    while (!done1 && lat1 < 10) begin
      @(posedge clk); #1;
      s1_valid = 1'b1; s1_in = 8'h11;
      lat1++;
      @(negedge clk);
    end
    check("n1_latency", lat1, LAT);
    check("n1_o", o1, 8'h9A);
    check("n1_idx", o1_idx, 0);
    $display("search n1 q=55 o=%h idx=%0d lat=%0d", o1, o1_idx, lat1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
